// File: rtl/puf_crp_authenticator.sv
// PUF challenge-response verifier: enrolled CRP table, Hamming-distance check and count timing.
// Optional consecutive-failure lockout enabled by defining PUF_AUTH_LOCKOUT_EN.
module puf_crp_authenticator #(
  parameter int HD_THRESHOLD = 2,
  parameter int PUF_TIMEOUT  = 255,
  parameter int COUNT_SLACK  = 4,
  parameter int MAX_FAILS    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enroll_we,
  input  logic [4:0]  enroll_addr,
  input  logic [15:0] enroll_data,
  input  logic        auth_start,
  input  logic [4:0]  auth_challenge,
  output logic        puf_generate,
  output logic [4:0]  puf_challenge,
  input  logic [15:0] puf_response,
  input  logic        puf_ready,
  output logic        counter_start,
  input  logic        scan_enable,
  input  logic        count_done,
  output logic        auth_busy,
  output logic        auth_done,
  output logic        auth_pass,
  output logic [2:0]  fail_code,
  output logic [4:0]  hamming_dist,
  output logic        lockout
);
  // state | meaning
  // IDLE  | waiting for auth_start, enrolment allowed
  // CHAL  | challenge driven to PUF, waiting for puf_ready
  // CMP   | Hamming distance of live vs enrolled response
  // COUNT | timing count_done against enrolled count
  // DONE  | one-cycle result pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHAL  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int TW = $clog2(PUF_TIMEOUT + 1);

  logic [2:0]    state;
  logic [15:0]   crp_mem [0:31];
  logic [31:0]   crp_valid;
  logic [4:0]    chal_q;
  logic [15:0]   resp_q;
  logic [TW-1:0] timer;
  logic [16:0]   cnt;
  logic          scan_seen;

  logic        entry_valid;
  logic [15:0] enrolled;
  logic [4:0]  hd_now;
  logic        hd_ok;
  logic [16:0] exp_lo;
  logic [16:0] exp_hi;
  logic        scan_any;
  logic        start_ok;
  logic        enroll_ok;

  assign entry_valid = crp_valid[chal_q];
  assign enrolled    = crp_mem[chal_q];
  assign hd_now      = 5'($countones(resp_q ^ enrolled));
  assign hd_ok       = (hd_now <= 5'(HD_THRESHOLD));
  assign exp_lo      = {1'b0, enrolled};
  assign exp_hi      = exp_lo + 17'(COUNT_SLACK);
  assign scan_any    = scan_seen | scan_enable;
  assign start_ok    = auth_start && (state == S_IDLE) && !lockout;
  assign enroll_ok   = enroll_we && (state == S_IDLE);

  // Combinational so that an async reset drops these immediately.
  assign puf_generate  = (state == S_CHAL) && entry_valid;
  assign puf_challenge = puf_generate ? chal_q : 5'd0;
  assign counter_start = (state == S_CMP) && hd_ok;
  assign auth_busy     = (state != S_IDLE);
  assign auth_done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (enroll_ok) crp_mem[enroll_addr] <= enroll_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      crp_valid    <= '0;
      chal_q       <= '0;
      resp_q       <= '0;
      timer        <= '0;
      cnt          <= '0;
      scan_seen    <= 1'b0;
      auth_pass    <= 1'b0;
      fail_code    <= 3'd0;
      hamming_dist <= 5'd0;
    end else begin
      if (enroll_ok) crp_valid[enroll_addr] <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            chal_q    <= auth_challenge;
            timer     <= '0;
            auth_pass <= 1'b0;
            fail_code <= 3'd0;
            state     <= S_CHAL;
          end
        end
        S_CHAL: begin
          if (!entry_valid) begin
            fail_code <= 3'd1;
            state     <= S_DONE;
          end else if (puf_ready) begin
            resp_q <= puf_response;
            state  <= S_CMP;
          end else if (timer == TW'(PUF_TIMEOUT - 1)) begin
            fail_code <= 3'd2;
            state     <= S_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CMP: begin
          hamming_dist <= hd_now;
          if (!hd_ok) begin
            fail_code <= 3'd3;
            state     <= S_DONE;
          end else begin
            cnt       <= 17'd1;
            scan_seen <= 1'b0;
            state     <= S_COUNT;
          end
        end
        S_COUNT: begin
          scan_seen <= scan_any;
          if (count_done) begin
            if ((cnt >= exp_lo) && (cnt <= exp_hi) && scan_any) auth_pass <= 1'b1;
            else fail_code <= 3'd4;
            state <= S_DONE;
          end else if (cnt >= exp_hi) begin
            // next count would exceed the allowed window
            fail_code <= 3'd4;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PUF_AUTH_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
    end else if (state == S_DONE) begin
      if (auth_pass) fail_cnt <= '0;
      else if (fail_cnt < FW'(MAX_FAILS)) fail_cnt <= fail_cnt + 1'b1;
    end
  end

  assign lockout = (fail_cnt >= FW'(MAX_FAILS));
`else
  // No failure counter in this build; MAX_FAILS is referenced only to keep it live.
  assign lockout = (MAX_FAILS < 0);
`endif

endmodule

// File: tb/tb_puf_crp_authenticator.sv
// Scoreboard bench for puf_crp_authenticator: stimulus pushes expected results,
// a monitor pops and compares on every auth_done.
module tb_puf_crp_authenticator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enroll_we;
  logic [4:0]  enroll_addr;
  logic [15:0] enroll_data;
  logic        auth_start;
  logic [4:0]  auth_challenge;
  logic        puf_generate;
  logic [4:0]  puf_challenge;
  logic [15:0] puf_response;
  logic        puf_ready;
  logic        counter_start;
  logic        scan_enable;
  logic        count_done;
  logic        auth_busy;
  logic        auth_done;
  logic        auth_pass;
  logic [2:0]  fail_code;
  logic [4:0]  hamming_dist;
  logic        lockout;

  puf_crp_authenticator dut (
    .clk(clk), .rst_n(rst_n),
    .enroll_we(enroll_we), .enroll_addr(enroll_addr), .enroll_data(enroll_data),
    .auth_start(auth_start), .auth_challenge(auth_challenge),
    .puf_generate(puf_generate), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .puf_ready(puf_ready),
    .counter_start(counter_start), .scan_enable(scan_enable), .count_done(count_done),
    .auth_busy(auth_busy), .auth_done(auth_done), .auth_pass(auth_pass),
    .fail_code(fail_code), .hamming_dist(hamming_dist), .lockout(lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    logic [2:0] code;
    logic [4:0] hd;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   gen_seen, cs_seen;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (puf_generate) gen_seen = 1'b1;
    if (counter_start) cs_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && auth_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_auth_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("auth_pass", 32'(auth_pass), 32'(e.pass));
        chk("fail_code", 32'(fail_code), 32'(e.code));
        chk("hamming_dist", 32'(hamming_dist), 32'(e.hd));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic enroll(input logic [4:0] a, input logic [15:0] d);
    enroll_we = 1'b1; enroll_addr = a; enroll_data = d;
    @(posedge clk); #1;
    enroll_we = 1'b0;
  endtask

  // rdy_dly < 0: no puf_ready. done_at < 0: no count_done. extra: start+enroll while busy.
  task automatic do_auth(input logic [4:0] ch, input logic [15:0] resp, input int rdy_dly,
                         input bit do_count, input int done_at, input bit scan, input bit extra,
                         input logic e_pass, input logic [2:0] e_code, input logic [4:0] e_hd,
                         input int e_lat);
    exp_t e;
    e.pass = e_pass; e.code = e_code; e.hd = e_hd; e.lat = e_lat; e.t0 = cyc;
    sb.push_back(e);
    auth_start = 1'b1; auth_challenge = ch;
    @(posedge clk); #1;
    auth_start = 1'b0; enroll_we = 1'b0;
    chk("busy_after_start", 32'(auth_busy), 32'd1);
    if (extra) begin
      auth_start = 1'b1; auth_challenge = 5'd9;
      enroll_we = 1'b1; enroll_addr = 5'd2; enroll_data = 16'h000F;
    end
    if (rdy_dly >= 0) begin
      for (int i = 0; i < rdy_dly; i++) begin
        @(posedge clk); #1;
        auth_start = 1'b0; enroll_we = 1'b0;
      end
      puf_ready = 1'b1; puf_response = resp;
      @(posedge clk); #1;
      puf_ready = 1'b0; auth_start = 1'b0; enroll_we = 1'b0;
      if (do_count) begin
        @(posedge clk); #1;
        scan_enable = scan;
        if (done_at > 0) begin
          repeat (done_at - 1) begin @(posedge clk); #1; end
          count_done = 1'b1;
          @(posedge clk); #1;
          count_done = 1'b0;
        end
      end
    end
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
      auth_start = 1'b0; enroll_we = 1'b0;
    end
    if (sb.size() != 0) begin
      chk("auth_done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    scan_enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enroll_we = 1'b0; enroll_addr = '0; enroll_data = '0;
    auth_start = 1'b0; auth_challenge = '0; puf_response = '0; puf_ready = 1'b0;
    scan_enable = 1'b0; count_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_generate", 32'(puf_generate), 32'd0);
    chk("rst_busy", 32'(auth_busy), 32'd0);
    chk("rst_outputs", {auth_done, auth_pass, fail_code, hamming_dist, counter_start, puf_challenge},
        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    enroll(5'd5, 16'h0010);
    do_auth(5'd5, 16'h0011, 3, 1, 17, 1'b1, 1'b0, 1'b1, 3'd0, 5'd1, 23);
    chk("pass_held", 32'(auth_pass), 32'd1);

    gen_seen = 1'b0;
    do_auth(5'd9, 16'h0000, -1, 0, -1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd1, 2);
    chk("unenrolled_no_generate", 32'(gen_seen), 32'd0);

    enroll(5'd2, 16'h00FF);
    cs_seen = 1'b0;
    do_auth(5'd2, 16'h000F, 2, 0, -1, 1'b0, 1'b1, 1'b0, 3'd3, 5'd4, 5);
    chk("hd_fail_no_counter_start", 32'(cs_seen), 32'd0);
    do_auth(5'd2, 16'h000F, 2, 0, -1, 1'b0, 1'b0, 1'b0, 3'd3, 5'd4, 5);

    do_auth(5'd5, 16'h0000, -1, 0, -1, 1'b0, 1'b0, 1'b0, 3'd2, 5'd4, 256);
    chk("timeout_generate_low", 32'(puf_generate), 32'd0);

    enroll(5'd7, 16'h0008);
    do_auth(5'd7, 16'h0008, 0, 1, 5, 1'b1, 1'b0, 1'b0, 3'd4, 5'd0, 8);
    do_auth(5'd7, 16'h0008, 0, 1, -1, 1'b1, 1'b0, 1'b0, 3'd4, 5'd0, 15);
    do_auth(5'd7, 16'h0008, 0, 1, 9, 1'b0, 1'b0, 1'b0, 3'd4, 5'd0, 12);
    do_auth(5'd7, 16'h0008, 0, 1, 8, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 11);
    do_auth(5'd7, 16'h0008, 0, 1, 12, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 15);

    enroll(5'd12, 16'hFF00);
    enroll_we = 1'b1; enroll_addr = 5'd12; enroll_data = 16'h0001;
    do_auth(5'd12, 16'h0001, 0, 1, 1, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 4);
    chk("lockout_tied_low", 32'(lockout), 32'd0);

    auth_start = 1'b1; auth_challenge = 5'd5;
    @(posedge clk); #1;
    auth_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_chal_generate", 32'(puf_generate), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_generate", 32'(puf_generate), 32'd0);
    chk("async_rst_busy", 32'(auth_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_results", {auth_pass, fail_code, hamming_dist}, 32'd0);
    @(posedge clk); #1;
    gen_seen = 1'b0;
    do_auth(5'd5, 16'h0010, -1, 0, -1, 1'b0, 1'b0, 1'b0, 3'd1, 5'd0, 2);
    chk("table_invalidated_no_generate", 32'(gen_seen), 32'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
